// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory bus between I-cache fills and
// D-cache fills/write-backs; registered commands, one-cycle ready pulses.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ICACHE_mem_read,
  input  logic [ADDR_W-1:0] ICACHE_mem_addr,
  output logic              ICACHE_mem_ready,
  output logic [LINE_W-1:0] ICACHE_mem_rdata,
  input  logic              DCACHE_mem_read,
  input  logic              DCACHE_mem_write,
  input  logic [ADDR_W-1:0] DCACHE_mem_addr,
  input  logic [LINE_W-1:0] DCACHE_mem_wdata,
  output logic              DCACHE_mem_ready,
  output logic [LINE_W-1:0] DCACHE_mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_e;

  state_e              state_q, state_d;
  logic                prio_q, prio_d;     // 1: D-cache wins the next tie
  logic                owner_q, owner_d;   // 1: D-cache owns the bus
  logic                op_r_q, op_r_d;     // 1: D transfer is a fill
  logic                mask_i_q, mask_i_d;
  logic                mask_d_q, mask_d_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                i_ready_q, i_ready_d;
  logic                d_ready_q, d_ready_d;
  logic [LINE_W-1:0]   i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0]   d_rdata_q, d_rdata_d;
  logic                req_i, req_d;

  assign req_i = ICACHE_mem_read & ~mask_i_q;
  assign req_d = (DCACHE_mem_read | DCACHE_mem_write) & ~mask_d_q;

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    op_r_d      = op_r_q;
    mask_i_d    = 1'b0;
    mask_d_d    = 1'b0;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        if (req_i && (!req_d || !prio_q)) begin
          state_d    = BUSY_I;
          prio_d     = 1'b1;
          mem_addr_d = ICACHE_mem_addr;
          mem_read_d = 1'b1;
        end else if (req_d) begin
          state_d     = BUSY_D;
          prio_d      = 1'b0;
          op_r_d      = DCACHE_mem_read;
          mem_addr_d  = DCACHE_mem_addr;
          mem_wdata_d = DCACHE_mem_wdata;
          mem_read_d  = DCACHE_mem_read;
          mem_write_d = ~DCACHE_mem_read;
        end
      end
      BUSY_I: begin
        mem_read_d  = 1'b1;
        mem_write_d = 1'b0;
        if (mem_ready) begin
          state_d    = RESP;
          owner_d    = 1'b0;
          i_rdata_d  = mem_rdata;
          i_ready_d  = 1'b1;
          mem_read_d = 1'b0;
        end
      end
      BUSY_D: begin
        mem_read_d  = op_r_q;
        mem_write_d = ~op_r_q;
        if (mem_ready) begin
          state_d     = RESP;
          owner_d     = 1'b1;
          d_rdata_d   = mem_rdata;
          d_ready_d   = 1'b1;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      RESP: begin
        // Owner still sees its own request for one cycle; hide it in IDLE.
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mask_i_d    = ~owner_q;
        mask_d_d    = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      owner_q     <= 1'b0;
      op_r_q      <= 1'b0;
      mask_i_q    <= 1'b0;
      mask_d_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      op_r_q      <= op_r_d;
      mask_i_q    <= mask_i_d;
      mask_d_q    <= mask_d_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_read         = mem_read_q;
  assign mem_write        = mem_write_q;
  assign mem_addr         = mem_addr_q;
  assign mem_wdata        = mem_wdata_q;
  assign ICACHE_mem_ready = i_ready_q;
  assign ICACHE_mem_rdata = i_rdata_q;
  assign DCACHE_mem_ready = d_ready_q;
  assign DCACHE_mem_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fills, write-back, contention, masking,
// reset abort and late arrival, with hand-computed expectations.
module tb_mem_arbiter;
  localparam int unsigned ADDR_W = 28;
  localparam int unsigned LINE_W = 128;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ICACHE_mem_read;
  logic [ADDR_W-1:0] ICACHE_mem_addr;
  logic              ICACHE_mem_ready;
  logic [LINE_W-1:0] ICACHE_mem_rdata;
  logic              DCACHE_mem_read;
  logic              DCACHE_mem_write;
  logic [ADDR_W-1:0] DCACHE_mem_addr;
  logic [LINE_W-1:0] DCACHE_mem_wdata;
  logic              DCACHE_mem_ready;
  logic [LINE_W-1:0] DCACHE_mem_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [LINE_W-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int grants, ready_i, ready_d, both_high, stray;

  localparam logic [LINE_W-1:0] DATA_A5 = {16{8'hA5}};
  localparam logic [LINE_W-1:0] WB_LINE = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [LINE_W-1:0] R1      = 128'h1111_0000_1111_0000_1111_0000_1111_0001;
  localparam logic [LINE_W-1:0] R2      = 128'h2222_0000_2222_0000_2222_0000_2222_0002;
  localparam logic [LINE_W-1:0] R3      = 128'h3333_0000_3333_0000_3333_0000_3333_0003;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ICACHE_mem_read(ICACHE_mem_read), .ICACHE_mem_addr(ICACHE_mem_addr),
    .ICACHE_mem_ready(ICACHE_mem_ready), .ICACHE_mem_rdata(ICACHE_mem_rdata),
    .DCACHE_mem_read(DCACHE_mem_read), .DCACHE_mem_write(DCACHE_mem_write),
    .DCACHE_mem_addr(DCACHE_mem_addr), .DCACHE_mem_wdata(DCACHE_mem_wdata),
    .DCACHE_mem_ready(DCACHE_mem_ready), .DCACHE_mem_rdata(DCACHE_mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [ADDR_W-1:0] obs, input logic [ADDR_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_l(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk_b({tag, "_mem_read"}, mem_read, 1'b0);
    chk_b({tag, "_mem_write"}, mem_write, 1'b0);
    chk_a({tag, "_mem_addr"}, mem_addr, '0);
    chk_l({tag, "_mem_wdata"}, mem_wdata, '0);
    chk_b({tag, "_i_ready"}, ICACHE_mem_ready, 1'b0);
    chk_b({tag, "_d_ready"}, DCACHE_mem_ready, 1'b0);
    chk_l({tag, "_i_rdata"}, ICACHE_mem_rdata, '0);
    chk_l({tag, "_d_rdata"}, DCACHE_mem_rdata, '0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    ICACHE_mem_read = 1'b0;  ICACHE_mem_addr = '0;
    DCACHE_mem_read = 1'b0;  DCACHE_mem_write = 1'b0;
    DCACHE_mem_addr = '0;    DCACHE_mem_wdata = '0;
    mem_ready = 1'b0;        mem_rdata = '0;
    step();
    step();
    chk_all_zero("rst");
    rst_n = 1'b1;

    // Lone I fill: request in cycle 0, memory completes in cycle 5
    ICACHE_mem_read = 1'b1; ICACHE_mem_addr = 28'h0000010;
    chk_b("i_c0_idle", mem_read, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 5) begin mem_ready = 1'b1; mem_rdata = DATA_A5; end
      chk_b("i_mem_read", mem_read, 1'b1);
      chk_b("i_mem_write", mem_write, 1'b0);
      chk_a("i_mem_addr", mem_addr, 28'h0000010);
      chk_b("i_early_ready", ICACHE_mem_ready, 1'b0);
      chk_b("i_d_ready_quiet", DCACHE_mem_ready, 1'b0);
    end
    step();
    mem_ready = 1'b0; mem_rdata = '0; ICACHE_mem_read = 1'b0;
    chk_b("i_ready_c6", ICACHE_mem_ready, 1'b1);
    chk_l("i_rdata_c6", ICACHE_mem_rdata, DATA_A5);
    chk_b("i_resp_no_cmd", mem_read, 1'b0);
    chk_b("i_d_ready_c6", DCACHE_mem_ready, 1'b0);
    chk_l("i_d_rdata_c6", DCACHE_mem_rdata, '0);
    step();
    chk_b("i_ready_single", ICACHE_mem_ready, 1'b0);
    step();
    chk_b("i_no_regrant", mem_read, 1'b0);

    // Simultaneous after reset: I first, then D write-back, then tie back to I
    reset_dut();
    ICACHE_mem_read = 1'b1; ICACHE_mem_addr = 28'h0000030;
    DCACHE_mem_write = 1'b1; DCACHE_mem_addr = 28'h0000020; DCACHE_mem_wdata = WB_LINE;
    step();
    chk_b("sim_i_read", mem_read, 1'b1);
    chk_b("sim_i_nowrite", mem_write, 1'b0);
    chk_a("sim_i_addr", mem_addr, 28'h0000030);
    mem_ready = 1'b1; mem_rdata = R1;
    step();
    mem_ready = 1'b0; ICACHE_mem_read = 1'b0;
    chk_b("sim_i_ready", ICACHE_mem_ready, 1'b1);
    chk_l("sim_i_rdata", ICACHE_mem_rdata, R1);
    step();
    chk_b("sim_idle_read", mem_read, 1'b0);
    chk_b("sim_idle_write", mem_write, 1'b0);
    step();
    chk_b("sim_d_write", mem_write, 1'b1);
    chk_b("sim_d_noread", mem_read, 1'b0);
    chk_a("sim_d_addr", mem_addr, 28'h0000020);
    chk_l("sim_d_wdata", mem_wdata, WB_LINE);
    mem_ready = 1'b1; mem_rdata = R2;
    step();
    mem_ready = 1'b0; DCACHE_mem_write = 1'b0;
    chk_b("sim_d_ready", DCACHE_mem_ready, 1'b1);
    chk_b("sim_d_i_quiet", ICACHE_mem_ready, 1'b0);
    chk_l("sim_d_rdata", DCACHE_mem_rdata, R2);
    chk_b("sim_d_resp_nowrite", mem_write, 1'b0);
    step();
    ICACHE_mem_read = 1'b1; ICACHE_mem_addr = 28'h0000040;
    DCACHE_mem_read = 1'b1; DCACHE_mem_addr = 28'h0000050;
    step();
    chk_a("sim_prio_back_i", mem_addr, 28'h0000040);
    chk_b("sim_prio_read", mem_read, 1'b1);
    mem_ready = 1'b1; mem_rdata = R3;
    step();
    mem_ready = 1'b0; ICACHE_mem_read = 1'b0;
    step();
    step();
    chk_a("sim_d_fill_addr", mem_addr, 28'h0000050);
    chk_b("sim_d_fill_read", mem_read, 1'b1);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0; DCACHE_mem_read = 1'b0;
    chk_l("sim_d_fill_rdata", DCACHE_mem_rdata, R3);
    step();

    // Continuous contention, memory answers in the first busy cycle
    ICACHE_mem_read = 1'b1; ICACHE_mem_addr = 28'h0000100;
    DCACHE_mem_read = 1'b1; DCACHE_mem_addr = 28'h0000200;
    grants = 0; ready_i = 0; ready_d = 0; both_high = 0;
    for (int c = 0; c < 100 && (ready_i + ready_d) < 10; c++) begin
      step();
      if (ICACHE_mem_ready && DCACHE_mem_ready) both_high++;
      if (ICACHE_mem_ready) ready_i++;
      if (DCACHE_mem_ready) ready_d++;
      if (mem_read) begin
        chk_a("rr_grant_order", mem_addr, (grants % 2 == 0) ? 28'h0000100 : 28'h0000200);
        grants++;
      end
      mem_ready = mem_read | mem_write;
      mem_rdata = LINE_W'(c);
    end
    ICACHE_mem_read = 1'b0; DCACHE_mem_read = 1'b0; mem_ready = 1'b0;
    chk_i("rr_grants", grants, 10);
    chk_i("rr_ready_i", ready_i, 5);
    chk_i("rr_ready_d", ready_d, 5);
    chk_i("rr_double_ready", both_high, 0);
    step();
    step();
    chk_b("rr_drained", mem_read, 1'b0);

    // Held request: masked one IDLE, granted again on the following IDLE
    ICACHE_mem_read = 1'b1; ICACHE_mem_addr = 28'h0000060;
    step();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk_b("held_ready", ICACHE_mem_ready, 1'b1);
    step();
    chk_b("held_masked_idle", mem_read, 1'b0);
    step();
    chk_b("held_no_grant_masked", mem_read, 1'b0);
    step();
    chk_b("held_regrant", mem_read, 1'b1);
    chk_a("held_regrant_addr", mem_addr, 28'h0000060);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    ICACHE_mem_read = 1'b0;
    step();
    chk_b("held_drop_no_grant", mem_read, 1'b0);
    step();
    chk_b("held_drop_still_idle", mem_read, 1'b0);

    // Reset mid-transfer in BUSY_D with a slow memory pending
    DCACHE_mem_read = 1'b1; DCACHE_mem_addr = 28'h0000070;
    step();
    chk_b("rstm_busy_d", mem_read, 1'b1);
    chk_a("rstm_busy_addr", mem_addr, 28'h0000070);
    step();
    step();
    rst_n = 1'b0; DCACHE_mem_read = 1'b0;
    step();
    rst_n = 1'b1;
    chk_all_zero("rstm");
    stray = 0;
    for (int c = 0; c < 22; c++) begin
      step();
      if (DCACHE_mem_ready || mem_read || mem_write) stray++;
    end
    chk_i("rstm_no_pulse", stray, 0);
    DCACHE_mem_read = 1'b1; DCACHE_mem_addr = 28'h0000074;
    step();
    chk_b("rstm_restart_read", mem_read, 1'b1);
    chk_a("rstm_restart_addr", mem_addr, 28'h0000074);
    mem_ready = 1'b1; mem_rdata = R1;
    step();
    mem_ready = 1'b0; DCACHE_mem_read = 1'b0;
    chk_b("rstm_restart_ready", DCACHE_mem_ready, 1'b1);
    chk_l("rstm_restart_rdata", DCACHE_mem_rdata, R1);
    step();

    // Reset while I owns the bus (prio favours D) restores I-first ties
    ICACHE_mem_read = 1'b1; ICACHE_mem_addr = 28'h0000078;
    step();
    chk_b("rstp_busy_i", mem_read, 1'b1);
    rst_n = 1'b0; ICACHE_mem_read = 1'b0;
    step();
    rst_n = 1'b1;
    chk_b("rstp_cleared", mem_read, 1'b0);
    ICACHE_mem_read = 1'b1; ICACHE_mem_addr = 28'h000007C;
    DCACHE_mem_read = 1'b1; DCACHE_mem_addr = 28'h000007E;
    step();
    chk_a("rstp_tie_to_i", mem_addr, 28'h000007C);
    ICACHE_mem_read = 1'b0; DCACHE_mem_read = 1'b0;
    reset_dut();

    // Late arrival: D raised in cycle 2 of an I transfer completing in cycle 6
    ICACHE_mem_read = 1'b1; ICACHE_mem_addr = 28'h0000080;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 2) begin DCACHE_mem_read = 1'b1; DCACHE_mem_addr = 28'h0000090; end
      if (c == 6) begin mem_ready = 1'b1; mem_rdata = R2; end
      chk_a("late_i_addr", mem_addr, 28'h0000080);
      chk_b("late_i_read", mem_read, 1'b1);
      chk_b("late_i_nowrite", mem_write, 1'b0);
    end
    step();
    mem_ready = 1'b0; ICACHE_mem_read = 1'b0;
    chk_b("late_i_ready", ICACHE_mem_ready, 1'b1);
    chk_l("late_i_rdata", ICACHE_mem_rdata, R2);
    chk_b("late_d_quiet", DCACHE_mem_ready, 1'b0);
    step();
    chk_b("late_mask_idle", mem_read, 1'b0);
    step();
    chk_b("late_d_grant", mem_read, 1'b1);
    chk_a("late_d_addr", mem_addr, 28'h0000090);
    mem_ready = 1'b1; mem_rdata = R3;
    step();
    mem_ready = 1'b0; DCACHE_mem_read = 1'b0;
    chk_b("late_d_ready", DCACHE_mem_ready, 1'b1);
    chk_l("late_d_rdata", DCACHE_mem_rdata, R3);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
